muldiv_ctrl: RTL and testbench

- Sequencer for the execute-stage iterative multiply/divide datapath.
- Accepts one RV64M request from execute over a valid/ready handshake and drives the datapath's operand, mode, iteration-counter and load/run controls.
- Watches the datapath's finished flag, selects quotient or remainder, sign-extends word (W) results, and returns one response per request.
- Flush aborts silently.

---
 rtl/muldiv_ctrl.sv | 151 +++++++++++++++
 tb/tb_muldiv_ctrl.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: sequencer for the iterative RV64M multiply/divide datapath.
// Optional MULDIV_FASTRESP_EN returns the result in the finishing RUN cycle.
module muldiv_ctrl #(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic             req_word,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  output logic [XLEN-1:0]  dp_a,
  output logic [XLEN-1:0]  dp_b,
  output logic             dp_sign,
  output logic             dp_mul_div,
  output logic             dp_width,
  output logic [CNT_W-1:0] dp_cnt,
  output logic             dp_reseted,
  input  logic [XLEN-1:0]  dp_out,
  input  logic [XLEN-1:0]  dp_r,
  input  logic             dp_finished
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    DONE
  } state_t;

  state_t state, state_d;

  logic [2:0]       lat_op;
  logic             lat_word;
  logic [XLEN-1:0]  lat_a, lat_b;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [XLEN-1:0]  data, data_d;
  logic [XLEN-1:0]  sel, result;
  logic             accept, unsup;

  assign accept = (state == IDLE) && req_valid && !flush;
  assign unsup  = !req_op[2] && (req_op[1:0] != 2'b00);

  assign sel    = (lat_op[2:1] == 2'b11) ? dp_r : dp_out;
  assign result = lat_word ? {{(XLEN-32){sel[31]}}, sel[31:0]} : sel;

  // W operands ride in the upper half of the datapath
  assign dp_a = lat_word ? {lat_a[31:0], {(XLEN-32){1'b0}}} : lat_a;
  assign dp_b = lat_word ? {lat_b[31:0], {(XLEN-32){1'b0}}} : lat_b;
  assign dp_sign = (lat_op == 3'b000) || (lat_op == 3'b100) ||
                   (lat_op == 3'b110);
  assign dp_mul_div = lat_op[2];
  assign dp_width   = lat_word;
  assign dp_cnt     = cnt;
  assign dp_reseted = (state == RUN);
  assign req_ready  = (state == IDLE);

`ifdef MULDIV_FASTRESP_EN
  assign resp_valid = (state == DONE) ||
                      ((state == RUN) && dp_finished && !flush);
  assign resp_data  = (state == RUN) ? result : data;
`else
  assign resp_valid = (state == DONE);
  assign resp_data  = data;
`endif

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    data_d  = data;
    unique case (state)
      IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (unsup) begin
            state_d = DONE;
            data_d  = '0;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        cnt_d   = '0;
        state_d = flush ? IDLE : RUN;
      end
      RUN: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (dp_finished) begin
          data_d = result;
`ifdef MULDIV_FASTRESP_EN
          state_d = resp_ready ? IDLE : DONE;
`else
          state_d = DONE;
`endif
        end else begin
          cnt_d = cnt + CNT_W'(1);
        end
      end
      DONE: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lat_op   <= '0;
      lat_word <= 1'b0;
      lat_a    <= '0;
      lat_b    <= '0;
      cnt      <= '0;
      data     <= '0;
    end else begin
      cnt  <= cnt_d;
      data <= data_d;
      if (accept) begin
        lat_op   <= req_op;
        lat_word <= req_word;
        lat_a    <= req_a;
        lat_b    <= req_b;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// tb_muldiv_ctrl: randomized self-checking bench for muldiv_ctrl with a
// behavioural datapath stub and a cycle-level reference model.
module tb_muldiv_ctrl;

`ifdef MULDIV_FASTRESP_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [2:0]  req_op;
  logic        req_word;
  logic [63:0] req_a, req_b;
  logic        flush;
  logic        resp_valid, resp_ready;
  logic [63:0] resp_data, dp_a, dp_b;
  logic        dp_sign, dp_mul_div, dp_width;
  logic [6:0]  dp_cnt;
  logic        dp_reseted;
  logic [63:0] dp_out, dp_r;
  logic        dp_finished;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  muldiv_ctrl dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_word(req_word),
    .req_a(req_a), .req_b(req_b), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data),
    .dp_a(dp_a), .dp_b(dp_b), .dp_sign(dp_sign),
    .dp_mul_div(dp_mul_div), .dp_width(dp_width),
    .dp_cnt(dp_cnt), .dp_reseted(dp_reseted),
    .dp_out(dp_out), .dp_r(dp_r), .dp_finished(dp_finished)
  );

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- RISC-V M arithmetic ----------------
  function automatic logic [63:0] sx32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] ext(input logic [63:0] v,
                                      input bit sgn, input bit w32);
    if (!w32) return v;
    return sgn ? sx32(v[31:0]) : {32'b0, v[31:0]};
  endfunction

  function automatic logic [63:0] mag(input logic [63:0] v, input bit sgn);
    return (sgn && v[63]) ? -v : v;
  endfunction

  function automatic logic [63:0] quo(input logic [63:0] a, b,
                                      input bit sgn, input bit w32);
    logic [63:0] x, y, q;
    x = ext(a, sgn, w32);
    y = ext(b, sgn, w32);
    if (y == 0) return '1;
    q = mag(x, sgn) / mag(y, sgn);
    return (sgn && (x[63] ^ y[63])) ? -q : q;
  endfunction

  function automatic logic [63:0] rem(input logic [63:0] a, b,
                                      input bit sgn, input bit w32);
    logic [63:0] x, y, r;
    x = ext(a, sgn, w32);
    y = ext(b, sgn, w32);
    if (y == 0) return x;
    r = mag(x, sgn) % mag(y, sgn);
    return (sgn && x[63]) ? -r : r;
  endfunction

  function automatic bit early_div(input logic [63:0] a, b,
                                   input bit sgn, input bit w32);
    logic [63:0] x, y;
    x = ext(a, sgn, w32);
    y = ext(b, sgn, w32);
    return (y == 0) || (mag(x, sgn) < mag(y, sgn));
  endfunction

  function automatic logic [63:0] ref_rd(input logic [2:0] op, input bit w,
                                         input logic [63:0] a, b);
    logic [63:0] v;
    case (op)
      3'b000: v = a * b;
      3'b100: v = quo(a, b, 1'b1, w);
      3'b101: v = quo(a, b, 1'b0, w);
      3'b110: v = rem(a, b, 1'b1, w);
      3'b111: v = rem(a, b, 1'b0, w);
      default: return '0;
    endcase
    return w ? sx32(v[31:0]) : v;
  endfunction

  function automatic bit ref_early(input logic [2:0] op, input bit w,
                                   input logic [63:0] a, b);
    if (op == 3'b000)
      return w ? (a[31:0] == 0 || b[31:0] == 0) : (a == 0 || b == 0);
    return early_div(a, b, (op == 3'b100 || op == 3'b110), w);
  endfunction

  // ---------------- datapath stub ----------------
  logic [63:0] st_a, st_b, st_q, st_r;
  logic        st_e;
  assign st_a = dp_width ? {32'b0, dp_a[63:32]} : dp_a;
  assign st_b = dp_width ? {32'b0, dp_b[63:32]} : dp_b;
  assign st_q = !dp_mul_div ? st_a * st_b : quo(st_a, st_b, dp_sign, dp_width);
  assign st_r = rem(st_a, st_b, dp_sign, dp_width);
  assign st_e = !dp_mul_div ? (st_a == 0 || st_b == 0)
                            : early_div(st_a, st_b, dp_sign, dp_width);
  assign dp_out = dp_width ? {32'hA5A55A5A, st_q[31:0]} : st_q;
  assign dp_r   = dp_width ? {32'h5A5AA5A5, st_r[31:0]} : st_r;
  assign dp_finished = dp_reseted &&
                       (st_e || dp_cnt == (dp_width ? 7'd32 : 7'd64));

  // ---------------- reference model ----------------
  bit          m_on = 0, busy = 0, unsup_m = 0;
  bit          after_reset = 0, cnt_clear = 0;
  int          age = 0, first = 0, n = 0;
  logic [2:0]  m_op;
  bit          m_word;
  logic [63:0] m_a, m_b, m_exp;

  function automatic bit exp_valid();
    if (!busy || age < first) return 1'b0;
    if (FAST && !unsup_m && age == first && flush) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_on = 1; busy = 0; after_reset = 1; cnt_clear = 1;
    end else if (m_on) begin
      if (busy) begin
        if (flush) begin
          busy = 0; cnt_clear = 1;
        end else if (exp_valid() && resp_ready) begin
          busy = 0; cnt_clear = 0;
        end else begin
          age++;
        end
      end else if (req_valid && !flush) begin
        busy = 1; age = 1;
        m_op = req_op; m_word = req_word; m_a = req_a; m_b = req_b;
        unsup_m = !req_op[2] && req_op != 3'b000;
        n = ref_early(req_op, req_word, req_a, req_b) ? 0
          : (req_word ? 32 : 64);
        first = unsup_m ? 1 : (FAST ? 2 + n : 3 + n);
        m_exp = ref_rd(req_op, req_word, req_a, req_b);
        after_reset = 0; cnt_clear = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_on && !reset) begin
      chk("req_ready", req_ready, !busy);
      chk("resp_valid", resp_valid, exp_valid());
      if (exp_valid()) chk("resp_data", resp_data, m_exp);
      if (!busy) chk("idle_reseted", dp_reseted, 0);
      if (!busy && cnt_clear) chk("idle_cnt", dp_cnt, 0);
      if (!busy && after_reset) begin
        chk("rst_data", resp_data, 0);
        chk("rst_dp_a", dp_a, 0);
        chk("rst_dp_b", dp_b, 0);
      end
      if (busy && !unsup_m && age <= 2 + n) begin
        chk("dp_a", dp_a, m_word ? {m_a[31:0], 32'b0} : m_a);
        chk("dp_b", dp_b, m_word ? {m_b[31:0], 32'b0} : m_b);
        chk("dp_sign", dp_sign,
            (m_op == 3'b000 || m_op == 3'b100 || m_op == 3'b110));
        chk("dp_mul_div", dp_mul_div, m_op[2]);
        chk("dp_width", dp_width, m_word);
        chk("dp_reseted", dp_reseted, age >= 2);
        chk("dp_cnt", dp_cnt, age < 2 ? 64'd0 : 64'(age - 2));
      end else if (busy && !unsup_m) begin
        chk("done_reseted", dp_reseted, 0);
        chk("done_cnt", dp_cnt, 64'(n));
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic int lat_of(input int x);
    return FAST ? x - 1 : x;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] op, input bit w,
                      input logic [63:0] a, b);
    int g = 0;
    while (!req_ready && g < 300) begin
      step();
      g++;
    end
    chk("req_ready_wait", req_ready, 1);
    req_valid = 1; req_op = op; req_word = w; req_a = a; req_b = b;
    step();
    req_valid = 0;
    req_a = {$urandom, $urandom};
    req_b = {$urandom, $urandom};
    req_op = 3'($urandom);
  endtask

  task automatic wait_resp(output logic [63:0] d, output int lat);
    lat = 1;
    while (!resp_valid && lat < 200) begin
      step();
      lat++;
    end
    chk("resp_timeout", resp_valid, 1);
    d = resp_data;
  endtask

  task automatic take();
    resp_ready = 1;
    step();
    resp_ready = 0;
  endtask

  task automatic lit(input string name, input logic [2:0] op, input bit w,
                     input logic [63:0] a, b, input logic [63:0] exp,
                     input int exp_lat);
    logic [63:0] d;
    int l;
    send(op, w, a, b);
    wait_resp(d, l);
    chk(name, d, exp);
    chk({name, "_lat"}, 64'(l), 64'(exp_lat));
    take();
  endtask

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0: return 64'd0;
      1: return 64'($urandom_range(0, 20));
      2: return '1;
      3: return 64'h8000_0000_0000_0000;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  initial begin
    logic [63:0] d;
    int l;
    logic [2:0] ops [10];
    ops = '{3'b000, 3'b100, 3'b101, 3'b110, 3'b111,
            3'b000, 3'b100, 3'b110, 3'b001, 3'b011};
    reset = 1; req_valid = 0; req_op = 0; req_word = 0;
    req_a = 0; req_b = 0; flush = 0; resp_ready = 0;
    repeat (3) @(posedge clk);
    #1;
    reset = 0;
    chk("init_ready", req_ready, 1);
    chk("init_valid", resp_valid, 0);
    chk("init_data", resp_data, 0);

    // DIV -20 / 3
    send(3'b100, 0, -64'sd20, 64'd3);
    wait_resp(d, l);
    chk("div_data", d, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("div_lat", 64'(l), 64'(lat_of(67)));
    chk("div_cnt", dp_cnt, 64);
    take();

    lit("remw", 3'b110, 1, 64'h0000_0000_FFFF_FFEC, 64'd3,
        64'hFFFF_FFFF_FFFF_FFFE, lat_of(35));
    lit("divuw0", 3'b101, 1, 64'd7, 64'd0, '1, lat_of(3));
    lit("remuw0", 3'b111, 1, 64'd7, 64'd0, 64'd7, lat_of(3));

    // MULW with a stalled consumer
    send(3'b000, 1, 64'h7FFF_FFFF, 64'd2);
    wait_resp(d, l);
    chk("mulw_data", d, 64'hFFFF_FFFF_FFFF_FFFE);
    chk("mulw_lat", 64'(l), 64'(lat_of(35)));
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_valid", resp_valid, 1);
      chk("stall_data", resp_data, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("stall_ready", req_ready, 0);
    end
    take();

    // flush mid-run
    send(3'b101, 0, 64'd100, 64'd7);
    l = 0;
    while (!(dp_reseted && dp_cnt == 7'd10) && l < 100) begin
      step();
      l++;
    end
    chk("flush_reach", dp_cnt, 10);
    flush = 1;
    step();
    flush = 0;
    chk("flush_idle", req_ready, 1);
    chk("flush_novalid", resp_valid, 0);
    chk("flush_cnt", dp_cnt, 0);
    step();
    lit("mul42", 3'b000, 0, 64'd6, 64'd7, 64'd42, lat_of(67));

    // flush in IDLE blocks acceptance
    req_valid = 1; req_op = 3'b000; req_a = 5; req_b = 5; flush = 1;
    step();
    req_valid = 0; flush = 0;
    chk("idle_flush", req_ready, 1);

    // reset during RUN
    send(3'b000, 0, 64'd123, 64'd456);
    repeat (5) step();
    reset = 1;
    step();
    reset = 0;
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", resp_valid, 0);
    chk("rst_resp", resp_data, 0);
    chk("rst_cnt", dp_cnt, 0);
    chk("rst_reseted", dp_reseted, 0);
    lit("mul_neg", 3'b000, 0, -64'sd3, 64'd5,
        64'hFFFF_FFFF_FFFF_FFF1, lat_of(67));

    lit("unsup", 3'b010, 0, 64'd5, 64'd6, 64'd0, 1);

    for (int i = 0; i < 40; i++) begin
      logic [2:0] op;
      bit w;
      logic [63:0] a, b;
      int mode;
      op = ops[$urandom_range(0, 9)];
      w = 1'($urandom_range(0, 1));
      a = pick();
      b = pick();
      mode = $urandom_range(0, 3);
      if (mode == 0) begin
        req_valid = 1; req_op = op; flush = 1;
        step();
        req_valid = 0; flush = 0;
      end
      send(op, w, a, b);
      if (mode == 1) begin
        repeat ($urandom_range(0, 6)) step();
        flush = 1;
        step();
        flush = 0;
      end else begin
        resp_ready = (mode == 2);
        wait_resp(d, l);
        chk("rand_data", d, ref_rd(op, w, a, b));
        repeat ($urandom_range(0, 3)) step();
        take();
      end
    end

    repeat (3) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
